// File: rtl/game_core_seq.sv
// Game-logic sequencer: validates the memory header, then services prioritised interrupts
// (frame tick -> object RMW + GPU draw, key event -> key latch). GAME_WATCHDOG_EN adds a GPU-wait timeout.
module game_core_seq #(
    parameter int unsigned         ADDR_W      = 16,
    parameter int unsigned         DATA_W      = 16,
    parameter int unsigned         IRQ_N       = 2,
    parameter logic [DATA_W-1:0]   MAGIC       = DATA_W'(16'h6A4D),
    parameter logic [ADDR_W-1:0]   OBJ_BASE    = ADDR_W'(16'h0010),
    parameter int unsigned         MAX_OBJ     = 8,
    parameter logic [ADDR_W-1:0]   KEY_ADDR    = ADDR_W'(16'h0002),
    parameter logic [7:0]          SWITCH_KEY  = 8'h76,
    parameter int unsigned         WDOG_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    output logic              SWITCH_REQUEST,
    output logic              FATAL_ERROR,
    output logic              MEM_ENABLE,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA_R,
    output logic [DATA_W-1:0] MEM_DATA_W,
    input  logic              GPU_READY,
    output logic              GPU_DRAW,
    input  logic [7:0]        KBD_KEY,
    input  logic [IRQ_N-1:0]  INT_IRQ,
    output logic              INT_IACK,
    output logic              INT_IEND
);

    localparam int unsigned CNT_W = $clog2(MAX_OBJ + 1);
    localparam int unsigned CH_W  = $clog2(IRQ_N);
`ifdef GAME_WATCHDOG_EN
    localparam int unsigned WD_W  = $clog2(WDOG_CYCLES + 1);
`endif

    typedef enum logic [3:0] {
        S_BOOT, S_HDR_REQ, S_HDR_CHK, S_CNT_REQ, S_CNT_LD, S_IDLE, S_ACK, S_OBJ_REQ,
        S_OBJ_WR, S_KEY_LD, S_KEY_WR, S_GPU_WAIT, S_DRAW, S_END, S_FATAL
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  idx, idx_n;
    logic [CH_W-1:0]   ch, ch_n;
    logic [7:0]        key_q, key_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              mem_en_q, mem_en_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              iack_q, iack_n;
    logic              iend_q, iend_n;
    logic              draw_q, draw_n;
    logic              sw_q, sw_n;
    logic              fatal_q, fatal_n;
`ifdef GAME_WATCHDOG_EN
    logic [WD_W-1:0]   wd_q, wd_n;
`endif

    // Next state, then the registered outputs decoded from the state being entered
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        ch_n     = ch;
        key_n    = key_q;
        wdata_n  = '0;
        mem_en_n = 1'b0;
        mem_we_n = 1'b0;
        addr_n   = '0;
        iack_n   = 1'b0;
        iend_n   = 1'b0;
        draw_n   = 1'b0;
        sw_n     = 1'b0;
        fatal_n  = 1'b0;
`ifdef GAME_WATCHDOG_EN
        wd_n     = wd_q;
`endif

        case (state)
            S_BOOT:    state_n = S_HDR_REQ;
            S_HDR_REQ: state_n = S_HDR_CHK;
            S_HDR_CHK: state_n = (MEM_DATA_R != MAGIC) ? S_FATAL : S_CNT_REQ;
            S_CNT_REQ: state_n = S_CNT_LD;
            S_CNT_LD: begin
                cnt_n   = (MEM_DATA_R > DATA_W'(MAX_OBJ)) ? CNT_W'(MAX_OBJ) : CNT_W'(MEM_DATA_R);
                state_n = S_IDLE;
            end
            S_IDLE: begin
                if (|INT_IRQ) begin
                    for (int i = IRQ_N - 1; i >= 0; i--) begin
                        if (INT_IRQ[i]) ch_n = CH_W'(i);
                    end
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                idx_n = '0;
                if (ch == CH_W'(0))      state_n = (cnt == '0) ? S_GPU_WAIT : S_OBJ_REQ;
                else if (ch == CH_W'(1)) state_n = S_KEY_LD;
                else                     state_n = S_END;
            end
            S_OBJ_REQ: state_n = S_OBJ_WR;
            S_OBJ_WR: begin
                idx_n   = idx + CNT_W'(1);
                state_n = (idx_n == cnt) ? S_GPU_WAIT : S_OBJ_REQ;
            end
            S_GPU_WAIT: begin
                if (GPU_READY) begin
                    state_n = S_DRAW;
                end
`ifdef GAME_WATCHDOG_EN
                else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
                    state_n = S_FATAL;
                end else begin
                    wd_n = wd_q + WD_W'(1);
                end
`endif
            end
            S_DRAW:   state_n = S_END;
            S_KEY_LD: begin
                key_n   = KBD_KEY;
                state_n = S_KEY_WR;
            end
            S_KEY_WR: state_n = S_END;
            S_END:    state_n = S_IDLE;
            S_FATAL:  state_n = S_FATAL;
            default:  state_n = S_BOOT;
        endcase

`ifdef GAME_WATCHDOG_EN
        if (state_n == S_GPU_WAIT && state != S_GPU_WAIT) wd_n = '0;
`endif

        case (state_n)
            S_HDR_REQ: begin
                mem_en_n = 1'b1;
                addr_n   = ADDR_W'(0);
            end
            S_CNT_REQ: begin
                mem_en_n = 1'b1;
                addr_n   = ADDR_W'(1);
            end
            S_ACK:     iack_n = 1'b1;
            S_OBJ_REQ: begin
                mem_en_n = 1'b1;
                addr_n   = OBJ_BASE + ADDR_W'(idx_n);
            end
            S_OBJ_WR: begin
                mem_en_n = 1'b1;
                mem_we_n = 1'b1;
                addr_n   = OBJ_BASE + ADDR_W'(idx_n);
            end
            S_KEY_WR: begin
                mem_en_n = 1'b1;
                mem_we_n = 1'b1;
                addr_n   = KEY_ADDR;
                wdata_n  = DATA_W'(key_n);
            end
            S_DRAW:    draw_n = 1'b1;
            S_END: begin
                iend_n = 1'b1;
                sw_n   = (ch_n == CH_W'(1)) && (key_n == SWITCH_KEY);
            end
            S_FATAL:   fatal_n = 1'b1;
            default:   ;
        endcase
    end

    // State and output registers; ENABLE low behaves exactly like RESET
    always_ff @(posedge CLK) begin
        if (RESET || !ENABLE) begin
            state    <= S_BOOT;
            cnt      <= '0;
            idx      <= '0;
            ch       <= '0;
            key_q    <= '0;
            wdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            iack_q   <= 1'b0;
            iend_q   <= 1'b0;
            draw_q   <= 1'b0;
            sw_q     <= 1'b0;
            fatal_q  <= 1'b0;
`ifdef GAME_WATCHDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            ch       <= ch_n;
            key_q    <= key_n;
            wdata_q  <= wdata_n;
            mem_en_q <= mem_en_n;
            mem_we_q <= mem_we_n;
            addr_q   <= addr_n;
            iack_q   <= iack_n;
            iend_q   <= iend_n;
            draw_q   <= draw_n;
            sw_q     <= sw_n;
            fatal_q  <= fatal_n;
`ifdef GAME_WATCHDOG_EN
            wd_q     <= wd_n;
`endif
        end
    end

    // Object write data only exists once the read returns, so it is formed from MEM_DATA_R directly
    assign MEM_DATA_W     = (state == S_OBJ_WR) ? MEM_DATA_R + DATA_W'(1) : wdata_q;
    assign MEM_ENABLE     = mem_en_q;
    assign MEM_WRITE      = mem_we_q;
    assign MEM_ADDR       = addr_q;
    assign INT_IACK       = iack_q;
    assign INT_IEND       = iend_q;
    assign GPU_DRAW       = draw_q;
    assign SWITCH_REQUEST = sw_q;
    assign FATAL_ERROR    = fatal_q;

endmodule
